regfile_rename: RTL

- Parametrised architectural register file for the out-of-order core, successor to the single-issue regfile.
- Each register holds a value plus a busy bit and a reorder-buffer tag, so renaming and forwarding are tracked at the register file.
- Sits between decode/dispatch (reads operands, renames rd), the ROB commit stage (writes results) and the flush logic (branch mispredict).
- Provides NREAD combinational read ports with commit-stage bypass.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_read_port.sv | 41 ++++
 rtl/regfile_rename.sv | 85 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the renaming register file: default widths, zero
// constants and the per-port read result record.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int TAGW_DEF = 4;

  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;
  localparam logic [TAGW_DEF-1:0] ZERO_TAG  = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] data;
    logic                busy;
    logic [TAGW_DEF-1:0] tag;
  } rd_result_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register-0 masking plus the commit-stage bypass
// that hands a committing value straight to a consumer still waiting on it.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int AW   = AW_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_vals [NREG],
  input  logic [NREG-1:0] i_busy,
  input  logic [TAGW-1:0] i_tags [NREG],
  input  logic            i_cmEn,
  input  logic [AW-1:0]   i_cmAddr,
  input  logic [TAGW-1:0] i_cmTag,
  input  logic [XLEN-1:0] i_cmData,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy,
  output logic [TAGW-1:0] o_tag
);

  logic w_bypass;

  // Bypass only when the commit belongs to the producer this entry still waits on.
  assign w_bypass = i_cmEn && (i_cmAddr == i_addr) && i_busy[i_addr] &&
                    (i_tags[i_addr] == i_cmTag);

  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    o_tag  = '0;
    if (i_addr != '0) begin
      o_data = w_bypass ? i_cmData : i_vals[i_addr];
      o_busy = i_busy[i_addr] && !w_bypass;
      o_tag  = i_tags[i_addr];
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy bit and ROB tag, updated
// by rename, commit and flush, and read through NREAD bypassing ports.
module regfile_rename
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = 32,
  parameter int AW    = AW_DEF,
  parameter int TAGW  = TAGW_DEF,
  parameter int NREAD = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  output logic [NREAD*TAGW-1:0] rd_tag,
  input  logic                  rn_en,
  input  logic [AW-1:0]         rn_addr,
  input  logic [TAGW-1:0]       rn_tag,
  input  logic                  cm_en,
  input  logic [AW-1:0]         cm_addr,
  input  logic [TAGW-1:0]       cm_tag,
  input  logic [XLEN-1:0]       cm_data,
  input  logic                  flush
);

  logic [XLEN-1:0] r_val [NREG];
  logic [NREG-1:0] r_busy;
  logic [TAGW-1:0] r_tag [NREG];

  logic w_cmValid;
  logic w_cmClears;
  logic w_rnValid;

  assign w_cmValid  = cm_en && (cm_addr != '0);
  assign w_cmClears = w_cmValid && r_busy[cm_addr] && (r_tag[cm_addr] == cm_tag);
  assign w_rnValid  = rn_en && (rn_addr != '0) && !flush;

  // Later assignments win: a same-edge rename overrides the commit's busy clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      if (w_cmValid) begin
        r_val[cm_addr] <= cm_data;
      end
      if (w_cmClears) begin
        r_busy[cm_addr] <= 1'b0;
      end
      if (flush) begin
        r_busy <= '0;
      end else if (w_rnValid) begin
        r_busy[rn_addr] <= 1'b1;
        r_tag[rn_addr]  <= rn_tag;
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    rf_read_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW),
      .TAGW (TAGW)
    ) u_port (
      .i_addr   (rd_addr[p*AW +: AW]),
      .i_vals   (r_val),
      .i_busy   (r_busy),
      .i_tags   (r_tag),
      .i_cmEn   (cm_en),
      .i_cmAddr (cm_addr),
      .i_cmTag  (cm_tag),
      .i_cmData (cm_data),
      .o_data   (rd_data[p*XLEN +: XLEN]),
      .o_busy   (rd_busy[p]),
      .o_tag    (rd_tag[p*TAGW +: TAGW])
    );
  end

endmodule
